cell_plot_scheduler: RTL and testbench
======================================

# cell_plot_scheduler

Shares the VGA adapter's single plot port between two cell-drawing requesters: requester 0 is the cursor/move datapath and requester 1 is the board-RAM redraw scan. Each granted request rasterises one CELL×CELL board square, one pixel per clock, with a colour chosen from the 2-bit cell select code. Arbitration is round-robin. This block replaces the ad-hoc select-multiplexer and plot helper that currently sit between those sources and `vga_adapter`.

## Interface
- `CELL`, default 12: cell edge in pixels; N = CELL*CELL pixels per request.
- `X0`, default 32: x pixel of the board's left edge.
- `Y0`, default 12: y pixel of the board's top edge.
- `clock  in  1`: 50 MHz system clock (CLOCK_50).
- `resetn  in  1`: reset, asynchronous, active-low. Clears all state and outputs.
- `req  in  2`: per-requester request level; bit i belongs to requester i.
- `cell_x0`, `cell_y0`  in  3 each: requester 0 cell column and row, 0..7.
- `cell_x1`, `cell_y1`  in  3 each: requester 1 cell column and row.
- `select0`, `select1`  in  2 each: cell code. 00 = empty, 01 = black disk, 10 = white disk, 11 = cursor outline.
- `gnt  out  2`: one-hot grant, held high for the whole service.
- `ack  out  2`: one-cycle done pulse to the granted requester.
- `busy  out  1`: high whenever the block is not IDLE.
- `plot  out  1`: write strobe to `vga_adapter`.
- `x_out  out  8`: pixel x.
- `y_out  out  7`: pixel y.
- `colour  out  3`: pixel colour, RGB, 1 bit per channel.

## Operation
- The FSM has three states: IDLE, DRAW and DONE. Reset enters IDLE.
- IDLE:
  - If `req` is non-zero at a rising edge, pick the winner.
  - With one request pending, that requester wins.
  - With both pending, the requester not served last wins. The `last` register resets to 1, so requester 0 wins the first tie.
  - On the same edge, latch the winner's cell_x, cell_y and select. Set `gnt[w]`, clear the column/row counters, and go to DRAW.
- Latched operands: requesters may change their operands once `gnt` is high. Operand changes during service have no effect.
- DRAW:
  - Each cycle advances col 0..CELL-1, wrapping into row 0..CELL-1. Scan order is row-major.
  - When col = row = CELL-1, go to DONE.
- DONE:
  - Pulse `ack[w]` for one cycle and clear `gnt`.
  - Update `last` to w, then return to IDLE.
- Pixel address:
  - x = X0 + cell_x*CELL + col, y = Y0 + cell_y*CELL + row.
  - Compute at 8 bits; truncate y to 7 bits.
  - With the default parameters the maximum is x = 127 and y = 107, so no overflow is possible.
- Colour map: 00 → 3'b010 (green), 01 → 3'b000, 10 → 3'b111, 11 → 3'b110 (yellow).
- Outline mode (select 11): `plot` is asserted only when col ∈ {0, CELL-1} or row ∈ {0, CELL-1}. Interior pixels are still stepped through, so latency is identical to the other codes.
- Requests arriving while busy stay pending and are not queued separately. A requester must keep `req` high until `ack`.
- If `req[i]` is still high in the cycle after `ack[i]`, it counts as a new request.
- Out-of-range cell coordinates cannot occur, since the fields are 3 bits wide.

## Timing
- E0 is the edge at which IDLE samples a non-zero `req`.
- After E0: `gnt` is high and `busy` is high.
- Pixel outputs are registered. Pixel k (k = 0..N-1) appears on `plot`/`x_out`/`y_out`/`colour` in the cycle after edge E(k+1).
- `ack[w]` is high for exactly the one cycle after E(N+1). `gnt` and `plot` are low from that same cycle.
- IDLE can sample the next request at E(N+2) at the earliest. Back-to-back throughput is therefore N+2 cycles per cell.
- `plot` is never high outside the N pixel cycles.
- Reset values: `gnt` = 0, `ack` = 0, `busy` = 0, `plot` = 0, `x_out` = 0, `y_out` = 0, `colour` = 0, `last` = 1.
- Reset mid-draw: `plot` drops immediately (asynchronously), no `ack` is issued, and the block restarts in IDLE.

## Structure
- Package `othello_pkg` holds:
  - the select-code constants (SEL_EMPTY, SEL_BLACK, SEL_WHITE, SEL_CURSOR);
  - the colour constants;
  - the default CELL/X0/Y0 values;
  - the FSM state typedef.
- Sub-module `cell_raster_counter` (parameter CELL): an enable-driven col/row counter with a `last` flag. Used once by this block and reusable by the board redraw scan.

## Test plan
- Single request: req = 01, cell (0,0), select 01.
  - Expect 144 plotted pixels, first (32,12) and last (43,23), all colour 000.
  - `ack[0]` high one cycle after E145.
- Tie: req = 11 from reset.
  - Requester 0 is served first, then requester 1, with no idle gap beyond 1 cycle.
  - Next tie (both held high) → requester 0 again, because `last` = 1 after serving requester 1.
- Outline: cell (7,7), select 11.
  - Exactly 44 `plot` strobes.
  - Corners (116,96) and (127,107) are present; interior (120,100) is never plotted.
- Operand change: after `gnt[1]`, change cell_x1 from 3 to 5. Every plotted x stays in 68..79.
- Reset mid-draw: assert `resetn` low at pixel 50.
  - `plot`, `gnt` and `busy` go to 0 immediately, and no `ack` is issued.
  - After release, req = 10 is served normally.

Source files
------------

// File: rtl/othello_pkg.sv
// Shared constants and types for the Othello board drawing path.
// Select codes, colours, board geometry defaults and the scheduler FSM state.
package othello_pkg;

  localparam int CELL_DEF = 12;
  localparam int X0_DEF   = 32;
  localparam int Y0_DEF   = 12;

  localparam logic [1:0] SEL_EMPTY  = 2'b00;
  localparam logic [1:0] SEL_BLACK  = 2'b01;
  localparam logic [1:0] SEL_WHITE  = 2'b10;
  localparam logic [1:0] SEL_CURSOR = 2'b11;

  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_WHITE  = 3'b111;
  localparam logic [2:0] COL_YELLOW = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [2:0] sel_colour(
    input logic [1:0] sel
  );
    logic [2:0] c;
    c = COL_GREEN;
    case (sel)
      SEL_BLACK:  c = COL_BLACK;
      SEL_WHITE:  c = COL_WHITE;
      SEL_CURSOR: c = COL_YELLOW;
      default:    c = COL_GREEN;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cell_raster_counter.sv
// Row-major col/row scan over one CELL x CELL square.
// Ports: clock, resetn, i_clr, i_en -> o_col, o_row, o_last.
module cell_raster_counter #(
  parameter  int CELL = 12,
  localparam int CW   = (CELL > 1) ? $clog2(CELL) : 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_row,
  output logic          o_last
);

  localparam logic [CW-1:0] MAX = CW'(CELL - 1);

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (r_col == MAX) begin
        r_col <= '0;
        r_row <= (r_row == MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = (r_col == MAX) && (r_row == MAX);

endmodule

// File: rtl/cell_plot_scheduler.sv
// Round-robin share of the VGA plot port between cursor (0) and redraw (1).
// Ports: req/cell_x*/cell_y*/select* in; gnt, ack, busy, plot, x_out, y_out, colour out.
module cell_plot_scheduler
  import othello_pkg::*;
#(
  parameter int CELL = CELL_DEF,
  parameter int X0   = X0_DEF,
  parameter int Y0   = Y0_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [2:0] cell_x0,
  input  logic [2:0] cell_y0,
  input  logic [2:0] cell_x1,
  input  logic [2:0] cell_y1,
  input  logic [1:0] select0,
  input  logic [1:0] select1,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic       busy,
  output logic       plot,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour
);

  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [CW-1:0] MAX = CW'(CELL - 1);

  state_t     r_state;
  logic       r_last;
  logic       r_w;
  logic [2:0] r_cx;
  logic [2:0] r_cy;
  logic [1:0] r_sel;
  logic [1:0] r_gnt;
  logic [1:0] r_ack;
  logic       r_plot;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_colour;

  logic [CW-1:0] w_col;
  logic [CW-1:0] w_row;
  logic          w_last;
  logic          w_clr;
  logic          w_en;
  logic          w_win;
  logic          w_edge;
  logic          w_pix_on;
  logic [7:0]    w_x;
  logic [6:0]    w_y;

  assign w_clr = (r_state == ST_IDLE);
  assign w_en  = (r_state == ST_DRAW);

  cell_raster_counter #(
    .CELL (CELL)
  ) u_cnt (
    .clock  (clock),
    .resetn (resetn),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_last (w_last)
  );

  // On a tie the requester not served last wins.
  assign w_win = (req == 2'b11) ? ~r_last : req[1];

  // y is formed at 7 bits, which equals the 8-bit sum truncated.
  assign w_x = 8'(X0) + 8'(r_cx) * 8'(CELL) + 8'(w_col);
  assign w_y = 7'(Y0) + 7'(r_cy) * 7'(CELL) + 7'(w_row);

  assign w_edge = (w_col == '0) || (w_col == MAX) ||
                  (w_row == '0) || (w_row == MAX);
  assign w_pix_on = (r_sel != SEL_CURSOR) || w_edge;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_w      <= 1'b0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_sel    <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_ack  <= '0;
          r_plot <= 1'b0;
          if (req != 2'b00) begin
            r_w     <= w_win;
            r_cx    <= w_win ? cell_x1 : cell_x0;
            r_cy    <= w_win ? cell_y1 : cell_y0;
            r_sel   <= w_win ? select1 : select0;
            r_gnt   <= {w_win, ~w_win};
            r_state <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          r_plot   <= w_pix_on;
          r_x      <= w_x;
          r_y      <= w_y;
          r_colour <= sel_colour(r_sel);
          if (w_last) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_plot  <= 1'b0;
          r_gnt   <= '0;
          r_ack   <= {r_w, ~r_w};
          r_last  <= r_w;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign ack    = r_ack;
  assign busy   = (r_state != ST_IDLE);
  assign plot   = r_plot;
  assign x_out  = r_x;
  assign y_out  = r_y;
  assign colour = r_colour;

endmodule

// File: tb/tb_cell_plot_scheduler.sv
// Randomised bench for cell_plot_scheduler.
// Transaction-level model: winner choice, pixel list, ack timing.
module tb_cell_plot_scheduler;

  localparam int CELL = 12;
  localparam int X0   = 32;
  localparam int Y0   = 12;
  localparam int N    = CELL * CELL;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] req = '0;
  logic [2:0] cell_x0 = '0;
  logic [2:0] cell_y0 = '0;
  logic [2:0] cell_x1 = '0;
  logic [2:0] cell_y1 = '0;
  logic [1:0] select0 = '0;
  logic [1:0] select1 = '0;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic       busy;
  logic       plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;

  always #5 clock = ~clock;

  cell_plot_scheduler #(
    .CELL (CELL),
    .X0   (X0),
    .Y0   (Y0)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .req     (req),
    .cell_x0 (cell_x0),
    .cell_y0 (cell_y0),
    .cell_x1 (cell_x1),
    .cell_y1 (cell_y1),
    .select0 (select0),
    .select1 (select1),
    .gnt     (gnt),
    .ack     (ack),
    .busy    (busy),
    .plot    (plot),
    .x_out   (x_out),
    .y_out   (y_out),
    .colour  (colour)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic       m_last;
  logic [2:0] tgt_x [2];
  logic [2:0] tgt_y [2];
  logic [1:0] tgt_s [2];

  int sv_w, sv_np, sv_hit;
  int sv_fx, sv_fy, sv_lx, sv_ly;
  int sv_xmin, sv_xmax;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [2:0] ref_colour(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b010;
      2'b01:   return 3'b000;
      2'b10:   return 3'b111;
      default: return 3'b110;
    endcase
  endfunction

  task automatic apply_ops();
    cell_x0 = tgt_x[0];
    cell_y0 = tgt_y[0];
    select0 = tgt_s[0];
    cell_x1 = tgt_x[1];
    cell_y1 = tgt_y[1];
    select1 = tgt_s[1];
  endtask

  task automatic rand_tgt(input int i);
    tgt_x[i] = 3'($urandom);
    tgt_y[i] = 3'($urandom);
    tgt_s[i] = 2'($urandom);
  endtask

  task automatic do_reset(input bit chk_vals);
    resetn = 1'b0;
    req = '0;
    repeat (2) @(negedge clock);
    if (chk_vals) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_plot", plot, 0);
      chk("rst_x", x_out, 0);
      chk("rst_y", y_out, 0);
      chk("rst_colour", colour, 0);
    end
    resetn = 1'b1;
    m_last = 1'b1;
  endtask

  // One full service: wait for grant, check every pixel cycle and the ack
  // cycle, then drive the next request vector (r & ~winner) | add.
  task automatic serve(input logic [1:0] add, input bit scramble,
                       input bit rnd);
    int wn, w, bad, k, row, col, xi, yi;
    logic [1:0] r, eg, ra, es;
    logic [2:0] ex, ey;
    bit ep;
    wn = 0;
    do begin
      @(negedge clock);
      wn++;
      if (wn == 1) chk("ack_pulse", ack, 0);
    end while (gnt == 2'b00 && wn < 20);
    if (gnt == 2'b00) begin
      chk("gnt_timeout", 0, 1);
      return;
    end
    r  = req;
    w  = (r == 2'b11) ? (m_last ? 0 : 1) : (r[1] ? 1 : 0);
    eg = (w == 1) ? 2'b10 : 2'b01;
    ex = (w == 1) ? cell_x1 : cell_x0;
    ey = (w == 1) ? cell_y1 : cell_y0;
    es = (w == 1) ? select1 : select0;
    sv_w = w;
    chk("grant_wait", wn, 1);
    chk("gnt", gnt, eg);
    chk("busy", busy, 1);
    bad = (plot !== 1'b0) ? 1 : 0;
    sv_np = 0; sv_hit = 0;
    sv_fx = -1; sv_fy = -1; sv_lx = -1; sv_ly = -1;
    sv_xmin = 999; sv_xmax = -1;
    for (int j = 1; j <= N + 1; j++) begin
      @(negedge clock);
      if (j <= N) begin
        k = j - 1;
        row = k / CELL;
        col = k % CELL;
        ep = (es != 2'b11) || col == 0 || col == CELL - 1 ||
             row == 0 || row == CELL - 1;
        if (plot !== ep || gnt !== eg || busy !== 1'b1 || ack !== 2'b00)
          bad++;
        if (plot === 1'b1) begin
          xi = x_out;
          yi = y_out;
          sv_np++;
          if (xi != (X0 + ex * CELL + col) % 256 ||
              yi != (Y0 + ey * CELL + row) % 128 ||
              colour !== ref_colour(es))
            bad++;
          if (sv_fx < 0) begin sv_fx = xi; sv_fy = yi; end
          sv_lx = xi; sv_ly = yi;
          if (xi < sv_xmin) sv_xmin = xi;
          if (xi > sv_xmax) sv_xmax = xi;
          if (xi == 120 && yi == 100) sv_hit++;
        end
        if (scramble && j < N) begin
          cell_x0 = 3'($urandom);
          cell_y0 = 3'($urandom);
          select0 = 2'($urandom);
          cell_x1 = (j == 1) ? 3'd5 : 3'($urandom);
          cell_y1 = 3'($urandom);
          select1 = 2'($urandom);
        end
      end else begin
        chk("ack", ack, eg);
        chk("gnt_clr", gnt, 0);
        chk("plot_clr", plot, 0);
        chk("busy_clr", busy, 0);
        m_last = (w == 1);
        ra = (r & ~eg) | add;
        if (rnd && ra == 2'b00) ra = 2'($urandom_range(1, 3));
        if (rnd) rand_tgt(w);
        req = ra;
        apply_ops();
      end
    end
    chk("pix_bad", bad, 0);
    chk("nplot", sv_np, (es == 2'b11) ? 4 * CELL - 4 : N);
  endtask

  initial begin
    int wn;
    do_reset(1'b1);

    // single request, black disk at cell (0,0)
    tgt_x[0] = 3'd0; tgt_y[0] = 3'd0; tgt_s[0] = 2'b01;
    tgt_x[1] = 3'd0; tgt_y[1] = 3'd0; tgt_s[1] = 2'b00;
    apply_ops();
    req = 2'b01;
    serve(2'b00, 1'b0, 1'b0);
    chk("single_w", sv_w, 0);
    chk("single_fx", sv_fx, 32);
    chk("single_fy", sv_fy, 12);
    chk("single_lx", sv_lx, 43);
    chk("single_ly", sv_ly, 23);

    // tie from reset, then a second tie after serving requester 1
    do_reset(1'b0);
    tgt_x[0] = 3'd1; tgt_y[0] = 3'd2; tgt_s[0] = 2'b10;
    tgt_x[1] = 3'd4; tgt_y[1] = 3'd5; tgt_s[1] = 2'b00;
    apply_ops();
    req = 2'b11;
    serve(2'b00, 1'b0, 1'b0);
    chk("tie1_w", sv_w, 0);
    serve(2'b11, 1'b0, 1'b0);
    chk("tie2_w", sv_w, 1);
    serve(2'b00, 1'b0, 1'b0);
    chk("tie3_w", sv_w, 0);
    serve(2'b00, 1'b0, 1'b0);
    chk("tie4_w", sv_w, 1);

    // cursor outline at (7,7)
    tgt_x[0] = 3'd7; tgt_y[0] = 3'd7; tgt_s[0] = 2'b11;
    apply_ops();
    req = 2'b01;
    serve(2'b00, 1'b0, 1'b0);
    chk("outl_fx", sv_fx, 116);
    chk("outl_fy", sv_fy, 96);
    chk("outl_lx", sv_lx, 127);
    chk("outl_ly", sv_ly, 107);
    chk("outl_interior", sv_hit, 0);

    // operand change during service
    tgt_x[1] = 3'd3; tgt_y[1] = 3'd1; tgt_s[1] = 2'b10;
    apply_ops();
    req = 2'b10;
    serve(2'b00, 1'b1, 1'b0);
    chk("opchg_xmin", sv_xmin, 68);
    chk("opchg_xmax", sv_xmax, 79);

    // reset in the middle of a draw
    rand_tgt(0);
    tgt_s[0] = 2'b10;
    apply_ops();
    req = 2'b01;
    wn = 0;
    do begin
      @(negedge clock);
      wn++;
    end while (gnt == 2'b00 && wn < 20);
    chk("mid_gnt", gnt, 1);
    repeat (51) @(negedge clock);
    chk("mid_plot_before", plot, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_plot", plot, 0);
    chk("mid_gnt_clr", gnt, 0);
    chk("mid_busy", busy, 0);
    rand_tgt(1);
    apply_ops();
    req = 2'b10;
    repeat (2) begin
      @(negedge clock);
      chk("mid_noack", ack, 0);
    end
    resetn = 1'b1;
    m_last = 1'b1;
    serve(2'b00, 1'b0, 1'b0);
    chk("mid_after_w", sv_w, 1);

    // randomised traffic
    rand_tgt(0);
    rand_tgt(1);
    apply_ops();
    req = 2'($urandom_range(1, 3));
    for (int t = 0; t < 16; t++)
      serve(2'($urandom), 1'($urandom), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
